rgb_decode: RTL and testbench

RGB_DECODE -- requirements
Module: rgb_decode

---
 rtl/rgb_decode_if.sv | 22 ++
 rtl/rgb_decode.sv | 144 ++++++++++++++
 tb/tb_rgb_decode.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rgb_decode_if.sv
// Video word stream in, decoded pixel stream out, shared by rgb_decode and its driver.
interface rgb_decode_if;
  logic [9:0]  vid;
  logic        vid_de;
  logic        vid_vs;
  logic [9:0]  data_out;
  logic        data_valid;
  logic [10:0] pix_cnt;
  logic [10:0] line_cnt;
  logic        frame_start;
  logic        err;

  modport master (
    output vid, vid_de, vid_vs,
    input  data_out, data_valid, pix_cnt, line_cnt, frame_start, err
  );

  modport slave (
    input  vid, vid_de, vid_vs,
    output data_out, data_valid, pix_cnt, line_cnt, frame_start, err
  );
endinterface

// File: rtl/rgb_decode.sv
// Recovers pixel data from Y/CB/CR word triplets: blue pixels carry data in CR, yellow in Y.
// Define RGB_DECODE_CHECK_EN to also flag pixels whose redundant fields are inconsistent.
module rgb_decode #(
  parameter logic [9:0]  BlueCb   = 10'h205,
  parameter logic [9:0]  CrBase   = 10'h200,
  parameter int unsigned LowLimit = 240,
  parameter logic [9:0]  YelCr    = 10'h0FF
) (
  input  logic  clk,
  input  logic  nreset,
  rgb_decode_if.slave bus
);

`ifdef RGB_DECODE_CHECK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  typedef enum logic [1:0] {StY, StCb, StCr} state_e;

  state_e      state_q, state_eff;
  logic [9:0]  y_q, cb_q;
  logic        de_q, vs_q;
  logic [9:0]  data_out_q;
  logic        data_valid_q;
  logic [10:0] pix_cnt_q, pix_idx_q, line_cnt_q;
  logic        line_seen_q;
  logic        frame_start_q, err_q;

  logic        de_rise, de_fall, vs_rise, pix_end;
  logic [10:0] cr_ext, cr_lo, cr_hi;
  logic        in_range, blue_cb, blue;
  logic [9:0]  diff, dec;
  logic        chk_hit;

  assign de_rise = bus.vid_de & ~de_q;
  assign de_fall = ~bus.vid_de & de_q;
  assign vs_rise = bus.vid_vs & ~vs_q;

  // A frame sync arriving with the CR word lets that pixel finish; otherwise it restarts.
  always_comb begin
    state_eff = state_q;
    if (de_rise || (vs_rise && !(state_q == StCr && bus.vid_de))) begin
      state_eff = StY;
    end
  end

  assign pix_end = bus.vid_de && (state_eff == StCr);

  assign cr_ext   = {1'b0, bus.vid};
  assign cr_lo    = {1'b0, CrBase};
  assign cr_hi    = cr_lo + 11'(LowLimit);
  assign in_range = (cr_ext >= cr_lo) && (cr_ext < cr_hi);
  assign blue_cb  = (cb_q == BlueCb);
  assign blue     = blue_cb && in_range;
  assign diff     = bus.vid - CrBase;
  assign dec      = blue ? diff : y_q;

  // Blue pixels mirror the data into Y; yellow pixels carry a fixed CR.
  assign chk_hit = (blue && (y_q != {diff[8:0], 1'b1})) ||
                   (!blue && (bus.vid != YelCr)) ||
                   (blue_cb && !in_range);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StY;
      y_q           <= '0;
      cb_q          <= '0;
      de_q          <= 1'b0;
      vs_q          <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      pix_cnt_q     <= '0;
      pix_idx_q     <= '0;
      line_cnt_q    <= '0;
      line_seen_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      de_q          <= bus.vid_de;
      vs_q          <= bus.vid_vs;
      data_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_start_q <= vs_rise;

      if (de_fall && (state_q != StY)) begin
        err_q   <= 1'b1;
        state_q <= StY;
      end else if (bus.vid_de) begin
        case (state_eff)
          StY: begin
            y_q     <= bus.vid;
            state_q <= StCb;
          end
          StCb: begin
            cb_q    <= bus.vid;
            state_q <= StCr;
          end
          StCr: begin
            data_out_q   <= dec;
            data_valid_q <= 1'b1;
            err_q        <= ChkEn & chk_hit;
            pix_cnt_q    <= pix_idx_q;
            pix_idx_q    <= pix_idx_q + 11'd1;
            line_seen_q  <= 1'b1;
            state_q      <= StY;
          end
          default: state_q <= StY;
        endcase
      end else if (vs_rise) begin
        state_q <= StY;
      end

      if (de_rise) begin
        pix_idx_q <= '0;
      end

      if (de_fall) begin
        line_seen_q <= 1'b0;
        if (line_seen_q) begin
          line_cnt_q <= line_cnt_q + 11'd1;
        end
      end

      // Frame sync wins over line bookkeeping; a coincident strobe keeps its own index.
      if (vs_rise) begin
        line_cnt_q <= '0;
        pix_idx_q  <= '0;
        if (!pix_end) begin
          pix_cnt_q <= '0;
        end
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.pix_cnt     = pix_cnt_q;
  assign bus.line_cnt    = line_cnt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_rgb_decode.sv
// Directed bench for rgb_decode: decode paths, counters, truncation, frame sync and reset.
module tb_rgb_decode;

`ifdef RGB_DECODE_CHECK_EN
  localparam logic ExpChk = 1'b1;
`else
  localparam logic ExpChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset;
  int   ncmp = 0;
  int   nfail = 0;
  int   nstrobe = 0;
  int   s0;

  always #5 clk = ~clk;

  rgb_decode_if bus ();

  rgb_decode dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always @(negedge clk) if (bus.data_valid === 1'b1) nstrobe++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [9:0] w);
    bus.vid    = w;
    bus.vid_de = 1'b1;
    step();
  endtask

  task automatic pix(input logic [9:0] y, input logic [9:0] cb, input logic [9:0] cr);
    word(y);
    word(cb);
    word(cr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.vid    = '0;
    bus.vid_de = 1'b0;
    bus.vid_vs = 1'b0;
    nreset     = 1'b0;
    repeat (2) step();
    chk("rst_dout", 32'(bus.data_out), 32'h0);
    chk("rst_dv", 32'(bus.data_valid), 32'h0);
    chk("rst_pix", 32'(bus.pix_cnt), 32'h0);
    chk("rst_line", 32'(bus.line_cnt), 32'h0);
    chk("rst_fs", 32'(bus.frame_start), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    nreset = 1'b1;
    step();

    // Blue pixel, then hold between strobes
    pix(10'h0A1, 10'h205, 10'h250);
    chk("blue_dout", 32'(bus.data_out), 32'h050);
    chk("blue_dv", 32'(bus.data_valid), 32'h1);
    chk("blue_pix", 32'(bus.pix_cnt), 32'h0);
    chk("blue_err", 32'(bus.err), 32'h0);
    word(10'h3FF);
    chk("hold_dv", 32'(bus.data_valid), 32'h0);
    chk("hold_dout", 32'(bus.data_out), 32'h050);
    word(10'h123);
    word(10'h0FF);
    chk("yel_dout", 32'(bus.data_out), 32'h3FF);
    chk("yel_pix", 32'(bus.pix_cnt), 32'h1);
    chk("yel_err", 32'(bus.err), 32'h0);
    pix(10'h3FF, 10'h123, 10'h0FE);
    chk("yelbad_dout", 32'(bus.data_out), 32'h3FF);
    chk("yelbad_err", 32'(bus.err), 32'(ExpChk));
    chk("yelbad_pix", 32'(bus.pix_cnt), 32'h2);

    // Blue range boundaries
    pix(10'h001, 10'h205, 10'h200);
    chk("lo_edge_dout", 32'(bus.data_out), 32'h000);
    chk("lo_edge_err", 32'(bus.err), 32'h0);
    pix(10'h1DF, 10'h205, 10'h2EF);
    chk("hi_edge_dout", 32'(bus.data_out), 32'h0EF);
    chk("hi_edge_err", 32'(bus.err), 32'h0);
    pix(10'h155, 10'h205, 10'h2F0);
    chk("above_dout", 32'(bus.data_out), 32'h155);
    chk("above_err", 32'(bus.err), 32'(ExpChk));
    pix(10'h2AA, 10'h205, 10'h1FF);
    chk("below_dout", 32'(bus.data_out), 32'h2AA);
    chk("below_err", 32'(bus.err), 32'(ExpChk));
    chk("below_pix", 32'(bus.pix_cnt), 32'h6);

    bus.vid_de = 1'b0;
    step();
    chk("eol_line", 32'(bus.line_cnt), 32'h1);
    chk("eol_err", 32'(bus.err), 32'h0);

    // Truncated triplet
    word(10'h0A1);
    word(10'h205);
    bus.vid_de = 1'b0;
    step();
    chk("trunc_err", 32'(bus.err), 32'h1);
    chk("trunc_dv", 32'(bus.data_valid), 32'h0);
    chk("trunc_line", 32'(bus.line_cnt), 32'h1);
    step();
    chk("trunc_err_end", 32'(bus.err), 32'h0);
    pix(10'h0A1, 10'h205, 10'h250);
    chk("after_dout", 32'(bus.data_out), 32'h050);
    chk("after_pix", 32'(bus.pix_cnt), 32'h0);
    chk("after_dv", 32'(bus.data_valid), 32'h1);

    // Frame sync coinciding with a CR word
    word(10'h3FF);
    word(10'h123);
    bus.vid_vs = 1'b1;
    word(10'h0FF);
    chk("vs_dv", 32'(bus.data_valid), 32'h1);
    chk("vs_dout", 32'(bus.data_out), 32'h3FF);
    chk("vs_pix", 32'(bus.pix_cnt), 32'h1);
    chk("vs_fs", 32'(bus.frame_start), 32'h1);
    chk("vs_line", 32'(bus.line_cnt), 32'h0);
    bus.vid_vs = 1'b0;
    pix(10'h0A1, 10'h205, 10'h250);
    chk("vs_next_pix", 32'(bus.pix_cnt), 32'h0);
    chk("vs_next_fs", 32'(bus.frame_start), 32'h0);
    chk("vs_next_dout", 32'(bus.data_out), 32'h050);
    pix(10'h0A1, 10'h205, 10'h250);
    chk("vs_next2_pix", 32'(bus.pix_cnt), 32'h1);

    // Asynchronous reset while in the CB state
    word(10'h0A1);
    nreset = 1'b0;
    #2;
    chk("arst_dout", 32'(bus.data_out), 32'h0);
    chk("arst_pix", 32'(bus.pix_cnt), 32'h0);
    chk("arst_dv", 32'(bus.data_valid), 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    pix(10'h3FF, 10'h123, 10'h0FF);
    chk("arst_fresh_dout", 32'(bus.data_out), 32'h3FF);
    chk("arst_fresh_dv", 32'(bus.data_valid), 32'h1);
    chk("arst_fresh_pix", 32'(bus.pix_cnt), 32'h0);
    bus.vid_de = 1'b0;
    step();
    chk("arst_line", 32'(bus.line_cnt), 32'h1);

    // Long line: pixel index wraps after 2047
    s0 = nstrobe;
    for (int i = 0; i < 2049; i++) begin
      pix(10'(i), 10'h000, 10'h0FF);
      chk("run_pix", 32'(bus.pix_cnt), 32'(i % 2048));
    end
    bus.vid_de = 1'b0;
    step();
    chk("run_strobes", 32'(nstrobe - s0), 32'd2049);
    chk("run_line", 32'(bus.line_cnt), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
